// File: rtl/mont_exp_requester.sv
// Initiator for a go/done Montgomery exponentiator: buffers one operand set,
// screens illegal moduli and trivial exponents, issues the job and returns Z.
module mont_exp_requester #(
    parameter int BITS    = 4,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_x,
    input  logic [BITS-1:0] in_e,
    input  logic [BITS-1:0] in_m,
    output logic            exp_go,
    output logic [BITS-1:0] exp_x,
    output logic [BITS-1:0] exp_e,
    output logic [BITS-1:0] exp_m,
    input  logic            exp_done,
    input  logic [BITS-1:0] exp_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_z,
    output logic            out_err,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT,
        DRAIN,
        RESP
    } state_t;

    state_t          state_q;
    logic            go_q;
    logic [BITS-1:0] x_q;
    logic [BITS-1:0] e_q;
    logic [BITS-1:0] m_q;
    logic            valid_q;
    logic [BITS-1:0] z_q;
    logic            err_q;
    logic [TW-1:0]   cnt_q;
    logic [TW-1:0]   cnt_d;

    assign cnt_d = cnt_q + TW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            x_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            valid_q <= 1'b0;
            z_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_x;
                        e_q     <= in_e;
                        m_q     <= in_m;
                        cnt_q   <= '0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!m_q[0]) begin
                        z_q     <= '0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else if (e_q == '0) begin
                        z_q     <= (m_q == BITS'(1)) ? '0 : BITS'(1);
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        go_q    <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    cnt_q <= cnt_d;
                    if (exp_done) begin
                        z_q     <= exp_z;
                        err_q   <= 1'b0;
                        go_q    <= 1'b0;
                        state_q <= DRAIN;
                    end else if (cnt_d == TW'(TIMEOUT)) begin
                        z_q     <= '0;
                        err_q   <= 1'b1;
                        go_q    <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Hold off until done falls so it cannot complete the next job.
                    if (!exp_done) begin
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    go_q    <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign exp_go    = go_q;
    assign exp_x     = x_q;
    assign exp_e     = e_q;
    assign exp_m     = m_q;
    assign out_valid = valid_q;
    assign out_z     = z_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_mont_exp_requester.sv
// Self-checking bench for mont_exp_requester with a behavioural exponentiator
// and a result scoreboard.
module tb_mont_exp_requester;

    localparam int BITS = 4;
    localparam int TO   = 15;
    localparam int TW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] in_x = '0;
    logic [BITS-1:0] in_e = '0;
    logic [BITS-1:0] in_m = '0;
    logic            exp_go;
    logic [BITS-1:0] exp_x;
    logic [BITS-1:0] exp_e;
    logic [BITS-1:0] exp_m;
    logic            exp_done = 1'b0;
    logic [BITS-1:0] exp_z = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [BITS-1:0] out_z;
    logic            out_err;
    logic            busy;

    int total = 0;
    int bad = 0;
    logic [BITS:0] expQ[$];

    int doneAfter = 0;
    int doneHold = 0;
    int goCycles = 0;
    int holdCnt = 0;

    mont_exp_requester #(.BITS(BITS), .TIMEOUT(TO), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_e(in_e), .in_m(in_m),
        .exp_go(exp_go), .exp_x(exp_x), .exp_e(exp_e), .exp_m(exp_m),
        .exp_done(exp_done), .exp_z(exp_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int modexp(input int x, input int e, input int m);
        int r;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * x) % m;
        return r;
    endfunction

    // Exponentiator model: raises done doneAfter cycles into go, holds it doneHold extra cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done = 1'b0;
            goCycles = 0;
            holdCnt = 0;
        end else if (exp_go === 1'b1) begin
            goCycles++;
            if (doneAfter > 0 && goCycles >= doneAfter) begin
                exp_done = 1'b1;
                exp_z = BITS'(modexp(int'(exp_x), int'(exp_e), int'(exp_m)));
                holdCnt = doneHold;
            end
        end else begin
            goCycles = 0;
            if (exp_done) begin
                if (holdCnt > 0) holdCnt--;
                else exp_done = 1'b0;
            end
        end
    end

    // Scoreboard: a handshake will happen at the next rising edge.
    always @(negedge clk) begin
        logic [BITS:0] exp;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got z=%0d err=%b want=no output", out_z, out_err);
            end else begin
                exp = expQ.pop_front();
                if ({out_err, out_z} !== exp) begin
                    bad++;
                    $display("FAIL sb_result got z=%0d err=%b want z=%0d err=%b",
                             out_z, out_err, exp[BITS-1:0], exp[BITS]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sendJob(input int x, input int e, input int m, input bit track,
                           input int wantZ, input bit wantErr);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready got=%b want=1", in_ready);
        end
        in_valid = 1'b1;
        in_x = BITS'(x);
        in_e = BITS'(e);
        in_m = BITS'(m);
        if (track) expQ.push_back({wantErr, BITS'(wantZ)});
        tick;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL accepted got in_ready=%b busy=%b want in_ready=0 busy=1", in_ready, busy);
        end
    endtask

    task automatic waitValid(input int x, input int e, input int m,
                             output int goCnt, output int cyc, output int unstable);
        goCnt = 0;
        cyc = 0;
        unstable = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (exp_go === 1'b1) begin
                goCnt++;
                if (exp_x !== BITS'(x) || exp_e !== BITS'(e) || exp_m !== BITS'(m)) unstable++;
            end
            tick;
            cyc++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL wait_out_valid got=%b after %0d cycles want=1", out_valid, cyc);
        end
    endtask

    task automatic checkJob(input string name, input int goCnt, input int wantGo,
                            input int cyc, input int wantCyc, input int unstable);
        total++;
        if (goCnt != wantGo) begin
            bad++;
            $display("FAIL %s_go_cycles got=%0d want=%0d", name, goCnt, wantGo);
        end
        total++;
        if (cyc != wantCyc) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=%0d", name, cyc, wantCyc);
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL %s_operands_stable got=%0d changes want=0", name, unstable);
        end
    endtask

    task automatic finishHandshake(input string name);
        tick;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_post_handshake got valid=%b in_ready=%b busy=%b want 0 1 0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        total++;
        if (exp_go !== 1'b0 || out_valid !== 1'b0 || out_z !== '0 || out_err !== 1'b0 ||
            exp_x !== '0 || exp_e !== '0 || exp_m !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got go=%b valid=%b z=%0d err=%b x=%0d e=%0d m=%0d busy=%b want all 0",
                     exp_go, out_valid, out_z, out_err, exp_x, exp_e, exp_m, busy);
        end
        rst_n = 1'b1;
        tick;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_legal;
        int g, c, u;
        doneAfter = 12;
        doneHold = 0;
        out_ready = 1'b1;
        sendJob(4, 3, 7, 1'b1, 1, 1'b0);
        waitValid(4, 3, 7, g, c, u);
        checkJob("legal", g, 12, c, 14, u);
        finishHandshake("legal");
    endtask

    task automatic test_even_modulus;
        int g, c, u;
        sendJob(4, 4, 6, 1'b1, 0, 1'b1);
        waitValid(4, 4, 6, g, c, u);
        checkJob("even_m", g, 0, c, 1, u);
        finishHandshake("even_m");
    endtask

    task automatic test_zero_exponent;
        int g, c, u;
        sendJob(5, 0, 7, 1'b1, 1, 1'b0);
        waitValid(5, 0, 7, g, c, u);
        checkJob("e0_m7", g, 0, c, 1, u);
        finishHandshake("e0_m7");
        sendJob(5, 0, 1, 1'b1, 0, 1'b0);
        waitValid(5, 0, 1, g, c, u);
        checkJob("e0_m1", g, 0, c, 1, u);
        finishHandshake("e0_m1");
    endtask

    task automatic test_timeout;
        int g, c, u;
        doneAfter = 0;
        sendJob(4, 3, 7, 1'b1, 0, 1'b1);
        waitValid(4, 3, 7, g, c, u);
        checkJob("timeout", g, TO, c, TO + 2, u);
        finishHandshake("timeout");
        doneAfter = TO;
        sendJob(2, 3, 5, 1'b1, 3, 1'b0);
        waitValid(2, 3, 5, g, c, u);
        checkJob("done_at_timeout", g, TO, c, TO + 2, u);
        finishHandshake("done_at_timeout");
    endtask

    task automatic test_back_to_back;
        int g, c, u, moved;
        logic [BITS-1:0] zHeld;
        logic errHeld;
        doneAfter = 5;
        doneHold = 3;
        out_ready = 1'b0;
        sendJob(2, 3, 5, 1'b1, 3, 1'b0);
        waitValid(2, 3, 5, g, c, u);
        checkJob("stale_done", g, 5, c, 5 + 2 + 3, u);
        total++;
        if (exp_done !== 1'b0) begin
            bad++;
            $display("FAIL stale_done_low got=%b want=0", exp_done);
        end
        zHeld = out_z;
        errHeld = out_err;
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (out_valid !== 1'b1 || out_z !== zHeld || out_err !== errHeld || in_ready !== 1'b0)
                moved++;
        end
        total++;
        if (moved != 0) begin
            bad++;
            $display("FAIL backpressure_hold got=%0d changed cycles want=0", moved);
        end
        out_ready = 1'b1;
        finishHandshake("backpressure");
        doneHold = 0;
        doneAfter = 7;
        sendJob(3, 5, 11, 1'b1, 1, 1'b0);
        waitValid(3, 5, 11, g, c, u);
        checkJob("next_job", g, 7, c, 9, u);
        finishHandshake("next_job");
    endtask

    task automatic test_reset_mid_wait;
        int n, leaked;
        doneAfter = 0;
        sendJob(9, 2, 13, 1'b0, 0, 1'b0);
        n = 0;
        while (exp_go !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        total++;
        if (exp_go !== 1'b1) begin
            bad++;
            $display("FAIL midreset_go_rise got=%b want=1", exp_go);
        end
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        total++;
        if (exp_go !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || exp_x !== '0) begin
            bad++;
            $display("FAIL midreset_state got go=%b valid=%b in_ready=%b x=%0d want 0 0 1 0",
                     exp_go, out_valid, in_ready, exp_x);
        end
        leaked = 0;
        for (int i = 0; i < 25; i++) begin
            tick;
            if (out_valid !== 1'b0 || exp_go !== 1'b0) leaked++;
        end
        total++;
        if (leaked != 0) begin
            bad++;
            $display("FAIL midreset_no_output got=%0d active cycles want=0", leaked);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset;
        test_legal;
        test_even_modulus;
        test_zero_exponent;
        test_timeout;
        test_back_to_back;
        test_reset_mid_wait;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d pending want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
